// File: rtl/reg_bank_arbiter.sv
// Register bank shared by two requesters over a req/done handshake.
// Round-robin pointer picks the winner when both request in IDLE.
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_a,
  input  logic                   we_a,
  input  logic [AW-1:0]          addr_a,
  input  logic [WIDTH-1:0]       wdata_a,
  output logic                   gnt_a,
  output logic                   done_a,
  input  logic                   req_b,
  input  logic                   we_b,
  input  logic [AW-1:0]          addr_b,
  input  logic [WIDTH-1:0]       wdata_b,
  output logic                   gnt_b,
  output logic                   done_b,
  output logic [WIDTH-1:0]       rdata,
  output logic [DEPTH*WIDTH-1:0] q_all
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic [WIDTH-1:0] rd_val;

  // owner_q: 0 = A, 1 = B; same encoding for ptr_q
  assign sel_we    = owner_q ? we_b    : we_a;
  assign sel_addr  = owner_q ? addr_b  : addr_a;
  assign sel_wdata = owner_q ? wdata_b : wdata_a;

  // addresses beyond DEPTH match no register and read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_addr == AW'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    regs_d  = regs_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    done_a  = 1'b0;
    done_b  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_a && req_b) owner_d = ptr_q;
        else if (req_a)     owner_d = 1'b0;
        else if (req_b)     owner_d = 1'b1;
        if (req_a || req_b) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        gnt_a = !owner_q;
        gnt_b = owner_q;
        if (sel_we) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (sel_addr == AW'(i)) regs_d[i] = sel_wdata;
          end
        end else begin
          rdata_d = rd_val;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        gnt_a   = !owner_q;
        gnt_b   = owner_q;
        done_a  = !owner_q;
        done_b  = owner_q;
        ptr_d   = !owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      rdata_q <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      regs_q  <= regs_d;
    end
  end

  assign rdata = rdata_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_q
    assign q_all[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule
